// File: rtl/fp_add_pkg.sv
// Shared binary32 constants, rounding-mode encodings and the field struct
// used by the floating_point_adder datapath.
package fp_add_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RDN = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RTZ = 2'b11;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/fp_lzc27.sv
// 27-bit leading-zero counter; an all-zero input reports 27.
module fp_lzc27 (
    input  logic [26:0] v_i,
    output logic [4:0]  cnt_o
);

    // Ascending scan: the highest set bit is the last one to write the count.
    always_comb begin
        cnt_o = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v_i[i]) cnt_o = 5'(26 - i);
        end
    end

endmodule

// File: rtl/floating_point_adder.sv
// binary32 add/subtract, four rounding modes, subnormals and specials, one
// output register. Optional FP_ADD_FLAGS_EN adds the registered flags port.
module floating_point_adder
    import fp_add_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        sub,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  round_mode,
    output logic        out_valid,
    output logic [31:0] s
`ifdef FP_ADD_FLAGS_EN
    ,
    output logic [3:0]  flags
`endif
);

    // Valid-only interface: in_valid high at a rising edge loads s and raises
    // out_valid for exactly that next cycle; otherwise s holds, out_valid is 0.
    fp32_t       fa, fb;
    logic        sb_eff, eff_sub, a_nan, b_nan, a_inf, b_inf;
    logic [7:0]  ea, eb, ex, ey, d;
    logic [23:0] ma, mb, mx, my;
    logic        sx;
    logic [49:0] wide;
    logic [26:0] x27, y27, m27;
    logic [27:0] sum28;
    logic [4:0]  lz;
    logic [9:0]  ex10, lz10, sh10, en, er;
    logic        g, r, st, inexact, inc, rs, ovf, to_inf;
    logic [24:0] mr;
    logic [23:0] mant;
    logic [31:0] s_d, s_q;
    logic        out_valid_q;

    assign fa      = a;
    assign fb      = b;
    assign sb_eff  = fb.sign ^ sub;
    assign eff_sub = fa.sign ^ sb_eff;
    assign a_nan   = (&fa.exp) & (|fa.frac);
    assign b_nan   = (&fb.exp) & (|fb.frac);
    assign a_inf   = (&fa.exp) & ~(|fa.frac);
    assign b_inf   = (&fb.exp) & ~(|fb.frac);
    assign ea      = (fa.exp == 8'd0) ? 8'd1 : fa.exp;
    assign eb      = (fb.exp == 8'd0) ? 8'd1 : fb.exp;
    assign ma      = {|fa.exp, fa.frac};
    assign mb      = {|fb.exp, fb.frac};

    always_comb begin
        if (a[30:0] >= b[30:0]) begin
            sx = fa.sign; ex = ea; mx = ma; ey = eb; my = mb;
        end else begin
            sx = sb_eff;  ex = eb; mx = mb; ey = ea; my = ma;
        end
        d    = ex - ey;
        wide = {my, 26'b0} >> d;
        y27  = (d >= 8'd26) ? {26'b0, |my} : {wide[49:24], |wide[23:0]};
        x27  = {mx, 3'b000};
        sum28 = eff_sub ? ({1'b0, x27} - {1'b0, y27}) : ({1'b0, x27} + {1'b0, y27});
    end

    fp_lzc27 u_lzc (
        .v_i   (sum28[26:0]),
        .cnt_o (lz)
    );

    always_comb begin
        ex10 = {2'b00, ex};
        lz10 = {5'b00000, lz};
        sh10 = 10'd0;
        if (sum28[27]) begin
            m27 = {sum28[27:2], sum28[1] | sum28[0]};
            en  = ex10 + 10'd1;
        end else begin
            // Stop at exponent 1 so tiny results come out as subnormals.
            sh10 = (lz10 > ex10 - 10'd1) ? ex10 - 10'd1 : lz10;
            m27  = sum28[26:0] << sh10;
            en   = ex10 - sh10;
        end

        g       = m27[2];
        r       = m27[1];
        st      = m27[0];
        inexact = g | r | st;
        rs      = sx;
        if (sum28 == 28'd0) rs = eff_sub ? (round_mode == RM_RDN) : sx;

        case (round_mode)
            RM_RNE:  inc = g & (r | st | m27[3]);
            RM_RDN:  inc = inexact & rs;
            RM_RUP:  inc = inexact & ~rs;
            RM_RTZ:  inc = 1'b0;
            default: inc = 1'b0;
        endcase

        mr = {1'b0, m27[26:3]} + {24'b0, inc};
        if (mr[24]) begin
            mant = mr[24:1];
            er   = en + 10'd1;
        end else begin
            mant = mr[23:0];
            er   = en;
        end

        ovf    = er >= 10'(2 * BIAS + 1);
        to_inf = (round_mode == RM_RNE) | ((round_mode == RM_RDN) & rs) |
                 ((round_mode == RM_RUP) & ~rs);
        if (ovf)
            s_d = to_inf ? {rs, 8'hFF, 23'h0} : {rs, 8'hFE, 23'h7FFFFF};
        else
            s_d = {rs, mant[23] ? er[7:0] : 8'h00, mant[22:0]};

        if (a_nan)                        s_d = {fa.sign, 8'hFF, 1'b1, fa.frac[21:0]};
        else if (b_nan)                   s_d = {fb.sign, 8'hFF, 1'b1, fb.frac[21:0]};
        else if (a_inf & b_inf & eff_sub) s_d = QNAN;
        else if (a_inf)                   s_d = {fa.sign, 8'hFF, 23'h0};
        else if (b_inf)                   s_d = {sb_eff, 8'hFF, 23'h0};
    end

`ifdef FP_ADD_FLAGS_EN
    logic [3:0] flags_d, flags_q;
    logic       invalid;

    always_comb begin
        invalid = (a_inf & b_inf & eff_sub) | (a_nan & ~fa.frac[22]) | (b_nan & ~fb.frac[22]);
        if (a_nan | b_nan | a_inf | b_inf)
            flags_d = {invalid, 3'b000};
        else
            flags_d = {1'b0, ovf, ~ovf & ~mant[23] & inexact, inexact | ovf};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        flags_q <= 4'h0;
        else if (in_valid) flags_q <= flags_d;
    end

    assign flags = flags_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= 32'h0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) s_q <= s_d;
        end
    end

    assign s         = s_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_floating_point_adder.sv
// Scoreboard bench for floating_point_adder: directed vectors plus random
// operands checked against an exact big-integer reference model.
module tb_floating_point_adder;

  logic        clk, rst_n, in_valid, sub, out_valid;
  logic [31:0] a, b, s;
  logic [1:0]  round_mode;
`ifdef FP_ADD_FLAGS_EN
  logic [3:0]  flags;
`endif

  int          n_vec, n_err;
  logic [31:0] exp_q[$];
  int          id_q[$];
  logic [31:0] last_s;
  logic        vld_exp;

  floating_point_adder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .sub        (sub),
    .a          (a),
    .b          (b),
    .round_mode (round_mode),
    .out_valid  (out_valid),
    .s          (s)
`ifdef FP_ADD_FLAGS_EN
    ,
    .flags      (flags)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one-cycle latency expectation for out_valid
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_exp <= 1'b0;
    else        vld_exp <= in_valid;
  end

  // value of x in units of 2^-149 (exact for every finite binary32)
  function automatic logic [299:0] units(input logic [31:0] v);
    logic [299:0] m;
    if (v[30:23] == 8'd0) m = 300'(v[22:0]);
    else                  m = 300'({1'b1, v[22:0]}) << (int'(v[30:23]) - 1);
    return m;
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                          input logic sb, input logic [1:0] rm);
    logic         sx, sy, rs, up;
    logic [299:0] mx, my, mag, q, rem, half;
    int           p, sh;
    sx = x[31];
    sy = y[31] ^ sb;
    if (x[30:23] == 8'hFF && x[22:0] != 0) return {x[31], 8'hFF, 1'b1, x[21:0]};
    if (y[30:23] == 8'hFF && y[22:0] != 0) return {y[31], 8'hFF, 1'b1, y[21:0]};
    if (x[30:23] == 8'hFF && y[30:23] == 8'hFF)
      return (sx == sy) ? {sx, 8'hFF, 23'h0} : 32'h7FC00000;
    if (x[30:23] == 8'hFF) return {sx, 8'hFF, 23'h0};
    if (y[30:23] == 8'hFF) return {sy, 8'hFF, 23'h0};
    mx = units(x);
    my = units(y);
    if (sx == sy)      begin mag = mx + my; rs = sx; end
    else if (mx >= my) begin mag = mx - my; rs = sx; end
    else               begin mag = my - mx; rs = sy; end
    if (mag == 0) return {(sx == sy) ? sx : (rm == 2'b01), 31'h0};
    if (mag < (300'(1) << 24)) return {rs, mag[30:0]};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    sh   = p - 23;
    q    = mag >> sh;
    rem  = mag - (q << sh);
    half = 300'(1) << (sh - 1);
    case (rm)
      2'b00:   up = (rem > half) || (rem == half && q[0]);
      2'b01:   up = (rem != 0) && rs;
      2'b10:   up = (rem != 0) && !rs;
      default: up = 1'b0;
    endcase
    q = q + 300'(up);
    if (q[24]) begin q = q >> 1; sh = sh + 1; end
    if (sh + 1 >= 255) begin
      if (rm == 2'b00 || (rm == 2'b01 && rs) || (rm == 2'b10 && !rs)) return {rs, 8'hFF, 23'h0};
      return {rs, 8'hFE, 23'h7FFFFF};
    end
    return {rs, 8'(sh + 1), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op(input logic [31:0] base);
    logic [31:0] v;
    int          k;
    v = $urandom;
    k = $urandom_range(0, 6);
    case (k)
      1: v[30:23] = base[30:23] + 8'($urandom_range(0, 30)) - 8'd15;
      2: v[30:23] = 8'h00;
      3: begin v[30:23] = 8'hFF; if ($urandom_range(0, 1) == 1) v[22:0] = 23'h0; end
      4: v = {1'($urandom_range(0, 1)), base[30:0] ^ 31'($urandom_range(0, 7))};
      5: v[30:23] = 8'($urandom_range(250, 254));
      6: v[30:0] = 31'h0;
      default: ;
    endcase
    return v;
  endfunction

  // driver
  task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic xs,
                      input logic [1:0] xrm, input logic [31:0] want);
    a = xa; b = xb; sub = xs; round_mode = xrm; in_valid = 1'b1;
    exp_q.push_back(want);
    id_q.push_back(n_vec);
    n_vec++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [31:0] w;
    int          id;
    if (!rst_n) begin
      last_s = 32'h0;
    end else begin
      if (out_valid !== vld_exp) begin
        n_err++;
        $display("FAIL out_valid: got %b want %b at %0t", out_valid, vld_exp, $time);
      end
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_result: got %h want no output", s);
        end else begin
          w  = exp_q.pop_front();
          id = id_q.pop_front();
          if (s !== w) begin
            n_err++;
            $display("FAIL result #%0d: got %h want %h", id, s, w);
          end
          last_s = w;
        end
      end else if (s !== last_s) begin
        n_err++;
        $display("FAIL hold: got %h want %h", s, last_s);
      end
    end
  end

  typedef struct {
    logic [31:0] a, b;
    logic        sub;
    logic [1:0]  rm;
    logic [31:0] want;
  } vec_t;

  vec_t dir[30];

  initial begin
    dir[0]  = '{32'h3C600011, 32'hBE820000, 1'b1, 2'd0, 32'h3E890001};
    dir[1]  = '{32'h3C600011, 32'hBE820000, 1'b1, 2'd1, 32'h3E890000};
    dir[2]  = '{32'h3C600011, 32'hBE820000, 1'b1, 2'd2, 32'h3E890001};
    dir[3]  = '{32'h3C600011, 32'hBE820000, 1'b1, 2'd3, 32'h3E890000};
    dir[4]  = '{32'h3C600011, 32'hBE820000, 1'b0, 2'd0, 32'hBE75FFFF};
    dir[5]  = '{32'h3C600011, 32'hBE820000, 1'b0, 2'd1, 32'hBE75FFFF};
    dir[6]  = '{32'h3C600011, 32'hBE820000, 1'b0, 2'd2, 32'hBE75FFFE};
    dir[7]  = '{32'h3C600011, 32'hBE820000, 1'b0, 2'd3, 32'hBE75FFFE};
    dir[8]  = '{32'h3FFFFFFF, 32'hB3800000, 1'b1, 2'd0, 32'h40000000};
    dir[9]  = '{32'h3FFFFFFF, 32'hB3800000, 1'b1, 2'd1, 32'h3FFFFFFF};
    dir[10] = '{32'h3FFFFFFF, 32'hB3800000, 1'b1, 2'd2, 32'h40000000};
    dir[11] = '{32'h3FFFFFFF, 32'hB3800000, 1'b1, 2'd3, 32'h3FFFFFFF};
    dir[12] = '{32'h3FFFFFFF, 32'hB3800000, 1'b0, 2'd0, 32'h3FFFFFFE};
    dir[13] = '{32'h3FFFFFFF, 32'hB3800000, 1'b0, 2'd1, 32'h3FFFFFFE};
    dir[14] = '{32'h3FFFFFFF, 32'hB3800000, 1'b0, 2'd2, 32'h3FFFFFFF};
    dir[15] = '{32'h3FFFFFFF, 32'hB3800000, 1'b0, 2'd3, 32'h3FFFFFFE};
    dir[16] = '{32'h7F800000, 32'h7F800000, 1'b0, 2'd0, 32'h7F800000};
    dir[17] = '{32'h7F800000, 32'h7F800000, 1'b1, 2'd0, 32'h7FC00000};
    dir[18] = '{32'h7F00FFFF, 32'h7FE0000F, 1'b0, 2'd0, 32'h7FE0000F};
    dir[19] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'd0, 32'h7F800000};
    dir[20] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'd3, 32'h7F7FFFFF};
    dir[21] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'd1, 32'h7F7FFFFF};
    dir[22] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'd2, 32'h7F800000};
    dir[23] = '{32'h7F00FFFF, 32'h00000000, 1'b0, 2'd0, 32'h7F00FFFF};
    dir[24] = '{32'h00800000, 32'h007FFFFF, 1'b0, 2'd0, 32'h00FFFFFF};
    dir[25] = '{32'h00000007, 32'h00000008, 1'b0, 2'd0, 32'h0000000F};
    dir[26] = '{32'h3F800000, 32'h3F800000, 1'b1, 2'd0, 32'h00000000};
    dir[27] = '{32'h3F800000, 32'h3F800000, 1'b1, 2'd1, 32'h80000000};
    dir[28] = '{32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1, 2'd2, 32'hFF7FFFFF};
    dir[29] = '{32'h80000000, 32'h00000000, 1'b1, 2'd0, 32'h80000000};
  end

  // stimulus
  initial begin
    logic [31:0] ra, rb;
    logic        rsub;
    logic [1:0]  rrm;
    int          budget;
    rst_n = 1'b0; in_valid = 1'b0; sub = 1'b0; a = 32'h0; b = 32'h0; round_mode = 2'd0;
    n_vec = 0; n_err = 0;
    #12;
    n_vec++;
    if (s !== 32'h0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got s=%h out_valid=%b want s=0 out_valid=0", s, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;

    foreach (dir[i]) send(dir[i].a, dir[i].b, dir[i].sub, dir[i].rm, dir[i].want);
    repeat (3) @(negedge clk);

    // asynchronous reset while a fresh result is presented
    send(32'h3FFFFFFF, 32'hB3800000, 1'b1, 2'd0, 32'h40000000);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (s !== 32'h0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got s=%h out_valid=%b want s=0 out_valid=0", s, out_valid);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 400; n++) begin
      ra   = rand_op($urandom);
      rb   = rand_op(ra);
      rsub = 1'($urandom_range(0, 1));
      rrm  = 2'($urandom_range(0, 3));
      send(ra, rb, rsub, rrm, ref_add(ra, rb, rsub, rrm));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending results want 0", exp_q.size());
    end
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
